serial_tx: RTL and testbench
============================

# serial_tx

Parallel-to-serial frame transmitter, the sending end of the single-bit line that the capture flop chain samples. Accepts one DATA_W-bit word per valid/ready handshake and drives it onto `tx` as a start bit, LSB-first data, optional even parity, and a stop bit. Each bit is held for CLKS_PER_BIT clock cycles. Sits between a parallel producer and the serial line.

## Interface
Parameters:
- DATA_W, 8, payload bits per frame; must be ≥ 1.
- CLKS_PER_BIT, 4, clock cycles each line bit is held; must be ≥ 1.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  word to send; sampled only on accept.
- in_valid  input  1  producer has a word.
- in_ready  output  1  transmitter can accept; high only in IDLE.
- tx  output  1  serial line; idle level 1.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- PARITY exists only when SERIAL_TX_PARITY_EN is defined.
- Accept: `in_valid && in_ready` at a posedge. The shift register loads `in_data`, the state becomes START, and the bit index and tick counter clear.
- IDLE: tx=1, in_ready=1, busy=0. `in_valid` without `in_ready` never occurs, because ready is high throughout IDLE.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx = shift_reg[0]. Every CLKS_PER_BIT cycles the register shifts right by one and the bit index increments. After bit DATA_W-1 completes, go to PARITY if enabled, otherwise STOP.
- PARITY: tx = XOR of the latched word (even parity), for CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- in_ready and busy are decoded combinationally from the state. tx is registered.
- Counter widths:
  - Tick counter: $clog2(CLKS_PER_BIT), minimum 1 bit. It wraps to 0 at CLKS_PER_BIT-1.
  - Bit index: $clog2(DATA_W), minimum 1 bit.
- Changes on in_data after accept have no effect on the frame in flight.

## Timing
- Reset values: tx=1, busy=0, in_ready=1, state IDLE, counters 0.
- Reset is asynchronous: asserting it mid-frame forces tx=1 immediately and abandons the frame. No partial frame resumes after reset.
- Latency: the cycle after the accepting edge, tx=0 (start bit begins).
- Frame length, from first start cycle to last stop cycle: CLKS_PER_BIT×(DATA_W+2), or CLKS_PER_BIT×(DATA_W+3) with parity.
- Back-to-back frames:
  - On leaving STOP the block spends at least one cycle in IDLE with tx=1.
  - A word presented with in_valid already high is accepted on that IDLE cycle.
  - Minimum inter-frame gap is therefore one clock.
- CLKS_PER_BIT=1: every state lasts exactly one cycle per bit. No extra stall cycles.

## Configuration
- SERIAL_TX_PARITY_EN defined: the PARITY state is compiled in and frames carry an even-parity bit after the data bits.
- SERIAL_TX_PARITY_EN undefined: the PARITY state and its XOR logic are absent, and DATA goes directly to STOP.
- Port list is identical in both cases.

## Structure
- Shared package `serial_pkg` contains:
  - typedef enum `serial_state_t` {IDLE, START, DATA, PARITY, STOP};
  - constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- The matching receiver imports `serial_pkg` as well.
- One sub-module, `bit_timer`: the CLKS_PER_BIT tick counter. It has clear and enable inputs and emits a one-cycle `tick` on the last cycle of each bit.

## Test plan
- Reset check: assert reset for 3 cycles, then release -> tx=1, busy=0, in_ready=1, and tx remains 1 for 20 idle cycles.
- Single frame: DATA_W=8, CLKS_PER_BIT=4, parity off, send 8'hA5.
  - tx = 0, 1,0,1,0,0,1,0,1, 1, each bit for 4 cycles (40 cycles total).
  - busy=1 throughout the frame; in_ready=0 throughout.
- Parity build: SERIAL_TX_PARITY_EN defined.
  - 8'hA5 -> parity bit 0.
  - 8'h07 -> parity bit 1.
  - Frame length 44 cycles.
- Back-to-back: hold in_valid=1 with 8'h01 then 8'hFF.
  - Exactly one tx=1 idle cycle between the stop bit of frame 1 and the start bit of frame 2.
  - Second payload is all ones.
- Data stability: change in_data to 8'h00 one cycle after accepting 8'h3C -> the serialized payload is still 8'h3C.
- Reset mid-frame: assert reset during data bit 3.
  - tx=1 in the same cycle, before the next edge.
  - After release: busy=0, in_ready=1, and no residual bits are emitted.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial line transmitter and its matching receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } serial_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and pulses tick on the last one.
// Latency: tick is combinational from the count; count updates on posedge clk.
// Backpressure: none; counts only while en is high, clear has priority.
// Ports: clk, reset (async, active-high), clear (restart the period),
//        en (count this cycle), tick (last cycle of the current bit period).
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Latency: start bit appears on tx the cycle after the accepting edge; frame is CLKS_PER_BIT*(DATA_W+2[+1]).
// Backpressure: in_ready high only in IDLE; at least one idle cycle between frames.
// Ports: clk, reset (async, active-high), in_data/in_valid/in_ready (word handshake),
//        tx (registered serial line, idles high), busy (frame in progress).
// Build option: define SERIAL_TX_PARITY_EN to add an even-parity bit after the data bits.
module serial_tx
   import serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx,
   output logic              busy
);

   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

   serial_state_t     state, state_n;
   logic [DATA_W-1:0] shift, shift_n;
   logic [IW-1:0]     idx, idx_n;
   logic              tx_n;
   logic              tick;
   logic              accept;
`ifdef SERIAL_TX_PARITY_EN
   logic              par, par_n;
`endif

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clear (accept),
      .en    (busy),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         shift <= '0;
         idx   <= '0;
         tx    <= LINE_IDLE;
`ifdef SERIAL_TX_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_n;
         shift <= shift_n;
         idx   <= idx_n;
         tx    <= tx_n;
`ifdef SERIAL_TX_PARITY_EN
         par   <= par_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      shift_n = shift;
      idx_n   = idx;
`ifdef SERIAL_TX_PARITY_EN
      par_n   = par;
`endif
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_n = START;
               shift_n = in_data;
               idx_n   = '0;
`ifdef SERIAL_TX_PARITY_EN
               // The shift register consumes the word, so the parity of the
               // latched word is captured here alongside it.
               par_n   = ^in_data;
`endif
            end
         end
         START: begin
            if (tick) state_n = DATA;
         end
         DATA: begin
            if (tick) begin
               shift_n = shift >> 1;
               idx_n   = idx + IW'(1);
               if (idx == LAST_BIT) begin
                  idx_n = '0;
`ifdef SERIAL_TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            if (tick) state_n = STOP;
         end
`endif
         STOP: begin
            if (tick) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // tx is registered, so it is decoded from the state being entered;
      // this puts the start bit on the line the cycle after accept.
      tx_n = LINE_IDLE;
      case (state_n)
         IDLE:    tx_n = LINE_IDLE;
         START:   tx_n = START_BIT;
         DATA:    tx_n = shift_n[0];
`ifdef SERIAL_TX_PARITY_EN
         PARITY:  tx_n = par_n;
`endif
         STOP:    tx_n = STOP_BIT;
         default: tx_n = LINE_IDLE;
      endcase
   end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: per-cycle comparison against a frame-level
// line model, plus literal checks on decoded frames, gaps and reset behaviour.
// Honours SERIAL_TX_PARITY_EN the same way the design does.
module tb_serial_tx;

   localparam int DW = 8;
   localparam int C  = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int NBITS = DW + 3;
`else
   localparam int NBITS = DW + 2;
`endif
   localparam int FRAME_LEN = C * NBITS;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          tx;
   logic          busy;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(C)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx       (tx),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- line model: queue of expected tx values, one per cycle
   logic exp_q[$];

   task automatic push_frame(input logic [DW-1:0] w);
      logic bits[$];
      bits.push_back(1'b0);
      for (int k = 0; k < DW; k++) bits.push_back(w[k]);
`ifdef SERIAL_TX_PARITY_EN
      bits.push_back(^w);
`endif
      bits.push_back(1'b1);
      foreach (bits[i]) for (int r = 0; r < C; r++) exp_q.push_back(bits[i]);
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) exp_q.delete();
      else if (exp_q.size() != 0) void'(exp_q.pop_front());
      else if (in_valid) push_frame(in_data);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("tx", {31'd0, tx}, {31'd0, (exp_q.size() != 0) ? exp_q[0] : 1'b1});
         check("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
         check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() == 0});
      end
   end

   // ---------------- frame monitor: decodes completed frames from the line
   logic samples[0:63];
   int   cur_len  = 0;
   int   idle_run = 0;
   logic [DW-1:0] pay_q[$];
   int   len_q[$];
   logic par_q[$];
   logic edge_q[$];  // start bit value, then stop bit value, per frame
   int   gap_q[$];

   always @(negedge clk) begin
      if (reset) begin
         cur_len  = 0;
         idle_run = 0;
      end else if (busy) begin
         if (cur_len == 0) begin
            gap_q.push_back(idle_run);
            idle_run = 0;
         end
         if (cur_len < 64) samples[cur_len] = tx;
         cur_len++;
      end else begin
         if (cur_len != 0) begin
            logic [DW-1:0] p;
            for (int k = 0; k < DW; k++) p[k] = samples[C * (1 + k) + C / 2];
            pay_q.push_back(p);
            len_q.push_back(cur_len);
            par_q.push_back(samples[C * (DW + 1) + C / 2]);
            edge_q.push_back(samples[C / 2]);
            edge_q.push_back(samples[(cur_len - 1) & 63]);
            cur_len = 0;
         end
         idle_run++;
      end
   end

   task automatic wait_frames(input int n);
      int cyc = 0;
      while (pay_q.size() < n && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (pay_q.size() < n) begin
         total++;
         bad++;
         $display("FAIL frame_timeout: got %0d frames expected %0d", pay_q.size(), n);
      end
   endtask

   task automatic wait_busy(input logic level);
      int cyc = 0;
      while (busy !== level && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (busy !== level) begin
         total++;
         bad++;
         $display("FAIL busy_timeout: got %0b expected %0b", busy, level);
      end
   endtask

   task automatic send(input logic [DW-1:0] w, input logic [DW-1:0] after);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = after;
   endtask

   task automatic check_frame(input string name, input logic [DW-1:0] w, input logic par);
      check({name, "_payload"}, {24'd0, pay_q.pop_front()}, {24'd0, w});
      check({name, "_len"}, len_q.pop_front(), FRAME_LEN);
      check({name, "_start"}, {31'd0, edge_q.pop_front()}, 32'd0);
      check({name, "_stop"}, {31'd0, edge_q.pop_front()}, 32'd1);
`ifdef SERIAL_TX_PARITY_EN
      check({name, "_parity"}, {31'd0, par_q.pop_front()}, {31'd0, par});
`else
      void'(par_q.pop_front());
      if (par) total += 0;
`endif
   endtask

   initial begin
      int nfr;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      chk_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_tx", {31'd0, tx}, 32'd1);
      end

      // single frame, then parity-distinguishing frame
      send(8'hA5, 8'h00);
      wait_frames(1);
      check_frame("a5", 8'hA5, 1'b0);
      send(8'h07, 8'h00);
      wait_frames(1);
      check_frame("07", 8'h07, 1'b1);

      // back-to-back with in_valid held high
      repeat (3) @(negedge clk);
      gap_q.delete();
      in_valid = 1'b1;
      in_data  = 8'h01;
      @(negedge clk);
      wait_busy(1'b1);
      in_data = 8'hFF;
      wait_busy(1'b0);
      wait_busy(1'b1);
      in_valid = 1'b0;
      wait_frames(2);
      check_frame("b2b1", 8'h01, 1'b1);
      check_frame("b2b2", 8'hFF, 1'b0);
      check("b2b_gap", (gap_q.size() >= 2) ? gap_q[gap_q.size() - 1] : -1, 1);

      // input word changes right after accept
      send(8'h3C, 8'h00);
      wait_frames(1);
      check_frame("3c", 8'h3C, 1'b0);

      // reset during data bit 3: accept edge, then start(4) + bits 0..2 (12) + 2
      repeat (2) @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h5A;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (18) @(posedge clk);
      #3;
      check("mid_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_tx", {31'd0, tx}, 32'd1);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      nfr = pay_q.size();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("post_rst_tx", {31'd0, tx}, 32'd1);
      end
      check("post_rst_frames", pay_q.size(), nfr);
      check("post_rst_ready", {31'd0, in_ready}, 32'd1);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
